// File: rtl/hex_display_mux.sv
// Time-multiplexed hex driver for a common-anode 7-segment display.
// Inputs are captured once per frame so a changing count never tears mid-scan.
module hex_display_mux #(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  lz_blank,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_DIGITS - 1);

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]      r_slot_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [4*N_DIGITS-1:0] r_snap_val;
  logic [N_DIGITS-1:0]   r_snap_en;
  logic [N_DIGITS-1:0]   r_snap_dp;
  logic [N_DIGITS-1:0]   r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic                  r_frame_tick;

  logic                  w_frame_start;
  logic                  w_drive;
  logic                  w_visible;
  logic [N_DIGITS-1:0]   w_sel;
  logic [3:0]            w_nib;
  logic                  w_en_bit;
  logic                  w_dp_bit;
  logic                  w_hi_zero;
  logic                  w_lz_hit;

  assign w_frame_start = (r_idx == '0) && (r_slot_cnt == '0);
  assign w_drive       = (r_slot_cnt >= BLANK_END);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_slot_cnt <= '0;
      r_idx      <= '0;
    end else if (r_slot_cnt == LAST_SLOT) begin
      r_slot_cnt <= '0;
      r_idx      <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    end else begin
      r_slot_cnt <= r_slot_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snap_val <= '0;
      r_snap_en  <= '0;
      r_snap_dp  <= '0;
    end else if (w_frame_start) begin
      r_snap_val <= value;
      r_snap_en  <= digit_en;
      r_snap_dp  <= dp_in;
    end
  end

  // Walk from the top digit down so w_hi_zero tracks "this nibble and all above are zero".
  always_comb begin
    w_sel     = '0;
    w_nib     = '0;
    w_en_bit  = 1'b0;
    w_dp_bit  = 1'b0;
    w_hi_zero = 1'b1;
    w_lz_hit  = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (r_snap_val[4*i +: 4] != 4'd0) w_hi_zero = 1'b0;
      if (IDX_W'(i) == r_idx) begin
        w_sel[i] = 1'b1;
        w_nib    = r_snap_val[4*i +: 4];
        w_en_bit = r_snap_en[i];
        w_dp_bit = r_snap_dp[i];
        w_lz_hit = (i != 0) && w_hi_zero;
      end
    end
  end

  assign w_visible = w_drive && w_en_bit && !(lz_blank && w_lz_hit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_an         <= '1;
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_an         <= w_visible ? ~w_sel : '1;
      r_seg        <= w_visible ? seg_decode(w_nib) : 7'h7F;
      r_dp         <= w_visible ? ~w_dp_bit : 1'b1;
      r_frame_tick <= w_frame_start;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_hex_display_mux.sv
// Bench for hex_display_mux (4 digits, 8-cycle slots, 2-cycle blanking guard).
module tb_hex_display_mux;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int n_checks = 0;
  int n_errors = 0;

  hex_display_mux #(.N_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .reset(reset), .value(value), .digit_en(digit_en), .dp_in(dp_in),
    .lz_blank(lz_blank), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: position within the frame is just edges-since-release mod FRAME.
  logic [6:0] dec_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  int         m_k;
  int         m_pos;
  int         mp;
  int         md;
  bit         mvis;
  logic [15:0] m_sv;
  logic [3:0]  m_se;
  logic [3:0]  m_sd;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic        exp_ft;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_k = 0; m_pos = -1; m_sv = '0; m_se = '0; m_sd = '0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_ft = 1'b0;
    end else begin
      mp = m_k % FRAME;
      md = mp / RD;
      mvis = ((mp % RD) >= BC) && m_se[md] &&
             !(lz_blank && md != 0 && (m_sv >> (4*md)) == 16'd0);
      exp_an  = mvis ? ~(4'b0001 << md) : 4'hF;
      exp_seg = mvis ? dec_tab[m_sv[4*md +: 4]] : 7'h7F;
      exp_dp  = mvis ? ~m_sd[md] : 1'b1;
      exp_ft  = (mp == 0);
      m_pos   = mp;
      if (mp == 0) begin
        m_sv = value; m_se = digit_en; m_sd = dp_in;
      end
      m_k++;
    end
  end

  task automatic wait_ft(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2*FRAME; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int cnt;
    value = 16'h1A70; digit_en = 4'hF; dp_in = 4'h0; lz_blank = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_init: an=%b seg=%b dp=%b ft=%b, expected 1111 1111111 1 0", an, seg, dp, frame_tick);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (frame_tick !== 1'b1) begin
      n_errors++; $display("FAIL ft_first: ft=%b, expected 1", frame_tick);
    end
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (frame_tick !== 1'b1 && cnt < 2*FRAME);
    n_checks++;
    if (cnt != FRAME) begin
      n_errors++; $display("FAIL ft_period: got %0d cycles, expected %0d", cnt, FRAME);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (an !== 4'b1110 || seg !== 7'b1000000) begin
      n_errors++; $display("FAIL drive_pre_reset: an=%b seg=%b, expected 1110 1000000", an, seg);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL async_reset: an=%b seg=%b dp=%b ft=%b, expected 1111 1111111 1 0", an, seg, dp, frame_tick);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (frame_tick !== 1'b1) begin
      n_errors++; $display("FAIL ft_after_release: ft=%b, expected 1", frame_tick);
    end
    for (int r = 0; r < 2; r++) begin
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (frame_tick !== 1'b1 && cnt < 2*FRAME);
      n_checks++;
      if (cnt != FRAME) begin
        n_errors++; $display("FAIL ft_repeat%0d: got %0d cycles, expected %0d", r, cnt, FRAME);
      end
    end
  endtask

  task automatic test_scan_order();
    bit ok;
    logic [6:0] seg_tab [4] = '{7'b1000000, 7'b1111000, 7'b0001000, 7'b1111001};
    logic [3:0] lit_an;
    logic [6:0] lit_seg;
    value = 16'h1A70; digit_en = 4'hF; dp_in = 4'h0; lz_blank = 1'b0;
    wait_ft(ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL scan_wait: no frame_tick seen, expected one"); end
    for (int j = 0; j < FRAME; j++) begin
      if (j > 0) @(negedge clk);
      lit_an  = ((j % RD) < BC) ? 4'hF : ~(4'b0001 << (j / RD));
      lit_seg = ((j % RD) < BC) ? 7'h7F : seg_tab[j / RD];
      n_checks++;
      if (an !== lit_an || seg !== lit_seg || dp !== 1'b1) begin
        n_errors++;
        $display("FAIL scan_order j=%0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1", j, an, seg, dp, lit_an, lit_seg);
      end
      n_checks++;
      if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
        n_errors++;
        $display("FAIL scan_model j=%0d: got %b %b %b %b, expected %b %b %b %b", j, an, seg, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
      end
    end
  endtask

  task automatic test_snapshot();
    bit ok;
    logic [6:0] lit_seg;
    value = 16'h0003; digit_en = 4'hF; dp_in = 4'h0; lz_blank = 1'b0;
    wait_ft(ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL snap_wait: no frame_tick seen, expected one"); end
    for (int j = 0; j < 2*FRAME; j++) begin
      if (j > 0) @(negedge clk);
      if ((j % FRAME) / RD == 0 && (j % RD) >= BC) begin
        lit_seg = (j < FRAME) ? 7'b0110000 : 7'b0010000;
        n_checks++;
        if (an !== 4'b1110 || seg !== lit_seg) begin
          n_errors++;
          $display("FAIL snapshot j=%0d: an=%b seg=%b, expected an=1110 seg=%b", j, an, seg, lit_seg);
        end
      end
      n_checks++;
      if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
        n_errors++;
        $display("FAIL snap_model j=%0d: got %b %b %b %b, expected %b %b %b %b", j, an, seg, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
      end
      if (j == 16) value = 16'h0009;
    end
  endtask

  task automatic test_lz_blank();
    bit ok;
    logic [15:0] vals  [3] = '{16'h0005, 16'h0000, 16'h0105};
    logic [3:0]  masks [3] = '{4'b0001, 4'b0001, 4'b0111};
    logic [6:0]  seg0  [3] = '{7'b0010010, 7'b1000000, 7'b0010010};
    logic [3:0]  lit_an;
    for (int ph = 0; ph < 3; ph++) begin
      value = vals[ph]; digit_en = 4'hF; dp_in = 4'h0; lz_blank = 1'b1;
      wait_ft(ok);
      n_checks++;
      if (!ok) begin n_errors++; $display("FAIL lz_wait%0d: no frame_tick seen, expected one", ph); end
      for (int j = 0; j < FRAME; j++) begin
        if (j > 0) @(negedge clk);
        lit_an = ((j % RD) >= BC && masks[ph][j / RD]) ? ~(4'b0001 << (j / RD)) : 4'hF;
        n_checks++;
        if (an !== lit_an) begin
          n_errors++; $display("FAIL lz_an ph=%0d j=%0d: an=%b, expected %b", ph, j, an, lit_an);
        end
        if (lit_an == 4'b1110) begin
          n_checks++;
          if (seg !== seg0[ph]) begin
            n_errors++; $display("FAIL lz_seg0 ph=%0d j=%0d: seg=%b, expected %b", ph, j, seg, seg0[ph]);
          end
        end
        n_checks++;
        if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
          n_errors++;
          $display("FAIL lz_model ph=%0d j=%0d: got %b %b %b %b, expected %b %b %b %b", ph, j, an, seg, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
        end
      end
    end
  endtask

  task automatic test_enable_dp();
    bit ok;
    value = 16'($urandom); digit_en = 4'b0101; dp_in = 4'b0001; lz_blank = 1'b0;
    wait_ft(ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL en_wait: no frame_tick seen, expected one"); end
    for (int j = 0; j < FRAME; j++) begin
      if (j > 0) @(negedge clk);
      n_checks++;
      if (an[1] !== 1'b1 || an[3] !== 1'b1) begin
        n_errors++; $display("FAIL en_mask j=%0d: an=%b, expected an[1]=an[3]=1", j, an);
      end
      n_checks++;
      if ((dp === 1'b0) != (an === 4'b1110)) begin
        n_errors++; $display("FAIL dp_digit0 j=%0d: dp=%b an=%b, expected dp low exactly when an=1110", j, dp, an);
      end
      n_checks++;
      if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
        n_errors++;
        $display("FAIL en_model j=%0d: got %b %b %b %b, expected %b %b %b %b", j, an, seg, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
      end
    end
  endtask

  task automatic test_invariant();
    for (int j = 0; j < 10*FRAME; j++) begin
      @(negedge clk);
      n_checks++;
      if ($countones(~an) > 1 || ((m_pos % RD) < BC && an !== 4'hF)) begin
        n_errors++; $display("FAIL invariant j=%0d: an=%b slot=%0d, expected <=1 low bit and 1111 in blank", j, an, m_pos % RD);
      end
      n_checks++;
      if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
        n_errors++;
        $display("FAIL inv_model j=%0d: got %b %b %b %b, expected %b %b %b %b", j, an, seg, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
      end
      if ($urandom_range(0, 7) == 0) begin
        value    = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
        digit_en = 4'($urandom);
        dp_in    = 4'($urandom);
        lz_blank = 1'($urandom);
      end
    end
  endtask

  initial begin
    value = '0; digit_en = '0; dp_in = '0; lz_blank = 1'b0;
    test_reset();
    test_scan_order();
    test_snapshot();
    test_lz_blank();
    test_enable_dp();
    test_invariant();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hex_display_mux.md
Name: hex_display_mux

Overview:
- Downstream consumer of the 4-bit counter outputs: time-multiplexes N nibbles onto a common-anode 7-segment display.
- Each digit shows as hex (0-F) with per-digit enable, decimal point and optional leading-zero blanking.
- Samples its input once per frame so a count changing mid-scan never tears on the display.
- Drives the board's an/seg/dp pins directly.

Parameters:
- N_DIGITS, 8: number of digits scanned (1..8).
- REFRESH_DIV, 100000: clock cycles per digit slot (>=2).
- BLANK_CYCLES, 1000: cycles at the start of each slot with all outputs off, as ghosting guard (0 <= BLANK_CYCLES < REFRESH_DIV).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- value  in  4*N_DIGITS  nibble i = value[4i+3:4i], displayed on digit i.
- digit_en  in  N_DIGITS  1 = digit i may light.
- dp_in  in  N_DIGITS  1 = decimal point of digit i on.
- lz_blank  in  1  1 = suppress leading zeros.
- an  out  N_DIGITS  active-low anode select.
- seg  out  7  active-low segments, {g,f,e,d,c,b,a}.
- dp  out  1  active-low decimal point.
- frame_tick  out  1  one-cycle pulse at start of each frame.

Behaviour:
- Reset (reset=0, asynchronous, no clock needed): slot_cnt=0, idx=0, snapshot=0, an=all 1, seg=7'h7F, dp=1, frame_tick=0.
- slot_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
- idx increments when slot_cnt==REFRESH_DIV-1 and wraps from N_DIGITS-1 to 0.
- Snapshot: when idx==0 and slot_cnt==0, the snapshot register loads value, digit_en and dp_in on that edge. These inputs are ignored at all other times. This includes the first cycle after reset release.
- Phase per slot:
  - BLANK while slot_cnt < BLANK_CYCLES.
  - DRIVE otherwise.
- All outputs are registered. The outputs in cycle t+1 reflect idx, slot_cnt and snapshot in cycle t.
- BLANK phase: an=all 1, seg=7'h7F, dp=1.
- DRIVE phase, digit idx is visible iff its snapshot digit_en bit is 1 and it is not leading-zero blanked.
  - Visible: an[idx]=0, all other an bits 1; seg=decode(snapshot nibble idx); dp=~snapshot dp_in[idx].
  - Not visible: BLANK-phase values.
- Leading-zero blanking: applies only when lz_blank=1. lz_blank is sampled live, not snapshotted. Digit i>0 is blanked iff snapshot nibbles i..N_DIGITS-1 are all zero. Digit 0 is never leading-zero blanked, so value 0 shows "0".
- Decode table (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- frame_tick: registered output, high for exactly one cycle, in the cycle after the state idx==0 and slot_cnt==0. Period = N_DIGITS*REFRESH_DIV cycles.
- At most one an bit is low in any cycle. No an bit is low in the BLANK phase.
- Reset asserted mid-slot forces the reset values immediately. After release, the scan restarts at digit 0 with a fresh snapshot.

Test Plan:
Directed tests use N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
1. Async reset: drive reset=0 mid-DRIVE, between clock edges. Outputs go to an=4'b1111, seg=7'h7F, dp=1 immediately. After release, the first frame_tick comes 1 cycle later and repeats every 32 cycles.
2. Scan order: value=16'h1A70, digit_en=4'hF, dp_in=0, lz_blank=0. Expected per slot, in each slot's 6 DRIVE cycles, 1-cycle offset:
   - an=1110, seg=1000000
   - an=1101, seg=1111000
   - an=1011, seg=0001000
   - an=0111, seg=1111001
   - The first 2 cycles of every slot show an=1111.
3. Snapshot: change value from 16'h0003 to 16'h0009 while idx=2. Digit 0 keeps showing 3 (0110000) for the rest of the frame. It shows 9 (0010000) from the next frame on.
4. Leading-zero blanking: value=16'h0005, lz_blank=1. Only an[0] ever goes low. Then value=16'h0000: digit 0 shows seg=1000000. Then value=16'h0105: digits 0-2 light, digit 3 stays dark.
5. Enable and dp: digit_en=4'b0101, dp_in=4'b0001. an[1] and an[3] never go low. dp=0 only while an=1110 in DRIVE.
6. Invariant check: random value, digit_en and lz_blank over 10 frames. The count of zero bits in an is always <=1, and an=1111 whenever slot_cnt<2.
